rom_streamer: RTL and testbench

- Read-side initiator for the team's synchronous-read ROM (1-cycle registered read latency).
- On a start command, drives ROM addresses from start_addr for length words. Collects the returned data and presents it as a valid/ready output stream, with m_last on the final word.
- Sits between a control FSM (issues start, waits for done) and a downstream consumer (e.g. a serializer or datapath loader).
- Full throughput of 1 word/cycle when m_ready is held high; lossless under arbitrary backpressure.

---
 rtl/rom_streamer.sv | 161 ++++++++++++++++
 tb/tb_rom_streamer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_streamer.sv
// rtl/rom_streamer.sv - streams start_addr..start_addr+length-1 of a 1-cycle-latency ROM onto a valid/ready port
// Optional abort input is compiled in with ROM_STREAMER_ABORT_EN.
module rom_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int LEN_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  length,
`ifdef ROM_STREAMER_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_rd_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [1:0]            last_q;
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            occ_q, occ_d;

  logic abort_w;
  logic pop;
  logic push;
  logic issue;
  logic last_issue;

`ifdef ROM_STREAMER_ABORT_EN
  assign abort_w = abort & ((state_q == S_RUN) | (state_q == S_DRAIN));
`else
  assign abort_w = 1'b0;
`endif

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = m_valid ? mem_q[rd_ptr_q] : '0;
  assign m_last  = m_valid & last_q[rd_ptr_q];
  assign pop     = m_valid & m_ready;
  assign push    = inflight_q & ~abort_w;

  // Issue only if the word would still fit after this cycle's pop; m_ready feeds this directly.
  assign issue = (state_q == S_RUN) & ~abort_w &
                 (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  assign last_issue = issue & ((issued_q + LEN_WIDTH'(1)) == len_q);

  assign rom_rd_addr = issue ? addr_q : rd_addr_q;
  assign busy        = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    issued_d        = issued_q;
    rd_addr_d       = rom_rd_addr;
    inflight_d      = issue;
    inflight_last_d = last_issue;
    occ_d           = occ_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_d   = start_addr;
            len_d    = length;
            issued_d = '0;
            state_d  = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
          issued_d = issued_q + LEN_WIDTH'(1);
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop & m_last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_w) begin
      state_d = S_DONE;
      occ_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      rd_addr_q       <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rd_addr_q       <= rd_addr_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  // Two-entry output FIFO; the last flag travels alongside each captured word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      last_q   <= 2'b00;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else if (abort_w) begin
      last_q   <= 2'b00;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q]  <= rom_rd_data;
        last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_rom_streamer.sv
// tb/tb_rom_streamer.sv - directed self-checking bench for rom_streamer
module tb_rom_streamer;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done;
  logic [AW-1:0] rom_rd_addr;
  logic [DW-1:0] rom_rd_data = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
`ifdef ROM_STREAMER_ABORT_EN
  logic          abort = 1'b0;
`endif

  rom_streamer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_addr  (start_addr),
    .length      (length),
`ifdef ROM_STREAMER_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .done        (done),
    .rom_rd_addr (rom_rd_addr),
    .rom_rd_data (rom_rd_data),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last)
  );

  always #5 clk = ~clk;

  // ROM model: word i = 0x10 + i, one cycle registered read.
  always @(posedge clk) rom_rd_data <= 8'h10 + {5'b00000, rom_rd_addr};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] beats[$];
  logic       lasts[$];
  int         beat_cyc[$];
  int         done_cyc[$];
  logic       any_valid = 1'b0;
  logic       stall_pend = 1'b0;
  logic       skip_stall = 1'b0;
  logic [7:0] stall_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend && !skip_stall) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(stall_data));
      end
      stall_pend = m_valid && !m_ready;
      stall_data = m_data;
      if (m_valid) any_valid = 1'b1;
      if (m_valid && m_ready) begin
        beats.push_back(m_data);
        lasts.push_back(m_last);
        beat_cyc.push_back(cyc);
      end
      if (done) done_cyc.push_back(cyc);
    end
  end

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear();
    beats.delete();
    lasts.delete();
    beat_cyc.delete();
    done_cyc.delete();
    any_valid = 1'b0;
  endtask

  task automatic cmd(input int a, input int l, output int sc);
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = AW'(a);
    length = LW'(l);
    sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cyc.size() == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cyc.size() == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag, input int addr, input int len);
    check({tag, "_count"}, 32'(beats.size()), 32'(len));
    for (int i = 0; i < len && i < beats.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), 32'(beats[i]), 32'(16 + (addr + i) % DEPTH));
      check($sformatf("%s_last%0d", tag, i), 32'(lasts[i]), 32'(i == len - 1));
    end
    check({tag, "_done_count"}, 32'(done_cyc.size()), 32'd1);
  endtask

  initial begin
    int sc;
    int n;
    int k;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(rom_rd_addr), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    rst = 1'b0;

    // Basic: addr 2, 4 words, full throughput.
    clear();
    cmd(2, 4, sc);
    check("basic_busy", 32'(busy), 32'd1);
    wait_done("basic", 40);
    check_stream("basic", 2, 4);
    check("basic_first_cyc", 32'(qget(beat_cyc, 0)), 32'(sc + 3));
    check("basic_last_cyc", 32'(qget(beat_cyc, 3)), 32'(sc + 6));
    check("basic_done_cyc", 32'(qget(done_cyc, 0)), 32'(sc + 7));
    check("basic_idle_busy", 32'(busy), 32'd0);

    // Wrap: 6,7,0,1,2.
    clear();
    cmd(6, 5, sc);
    wait_done("wrap", 40);
    check_stream("wrap", 6, 5);
    check("wrap_last_cyc", 32'(qget(beat_cyc, 4)), 32'(sc + 7));

    // Backpressure: ready pattern 1,0,0 repeating.
    clear();
    cmd(0, 6, sc);
    k = 0;
    n = 0;
    while (done_cyc.size() == 0 && n < 80) begin
      m_ready = (k % 3 == 0);
      k++;
      @(posedge clk); #1;
      n++;
    end
    m_ready = 1'b1;
    if (done_cyc.size() == 0) check("bp_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_stream("bp", 0, 6);

    // Zero length.
    clear();
    cmd(0, 0, sc);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_done_now", 32'(done), 32'd1);
    wait_done("zero", 10);
    check("zero_done_cyc", 32'(qget(done_cyc, 0)), 32'(sc + 1));
    check("zero_done_count", 32'(done_cyc.size()), 32'd1);
    check("zero_no_valid", 32'(any_valid), 32'd0);

    // Reset after two beats of an 8-word command.
    clear();
    cmd(0, 8, sc);
    n = 0;
    while (beats.size() < 2 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("rstmid_two_beats", 32'(beats.size() >= 2), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_addr", 32'(rom_rd_addr), 32'd0);
    check("rstmid_valid", 32'(m_valid), 32'd0);
    check("rstmid_last", 32'(m_last), 32'd0);
    check("rstmid_data", 32'(m_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rstmid_no_done", 32'(done_cyc.size()), 32'd0);
    check("rstmid_idle", 32'(busy), 32'd0);

    // Fresh command after reset, with a start pulsed during RUN.
    clear();
    cmd(5, 3, sc);
    @(posedge clk); #1;
    check("busy_during_run", 32'(busy), 32'd1);
    start = 1'b1;
    start_addr = AW'(0);
    length = LW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("after_rst", 40);
    check_stream("after_rst", 5, 3);
    repeat (4) @(posedge clk);
    #1;
    check("ignored_start_beats", 32'(beats.size()), 32'd3);
    check("ignored_start_busy", 32'(busy), 32'd0);

`ifdef ROM_STREAMER_ABORT_EN
    // Abort after the third beat of 8.
    clear();
    cmd(0, 8, sc);
    n = 0;
    while (beats.size() < 3 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_three_beats", 32'(beats.size()), 32'd3);
    skip_stall = 1'b1;
    abort = 1'b1;
    m_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid_next", 32'(m_valid), 32'd0);
    check("abort_done_next", 32'(done), 32'd1);
    check("abort_busy_next", 32'(busy), 32'd0);
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    skip_stall = 1'b0;
    check("abort_beats", 32'(beats.size()), 32'd3);
    check("abort_no_valid_after", 32'(m_valid), 32'd0);
    check("abort_done_count", 32'(done_cyc.size()), 32'd1);
    k = 0;
    for (int i = 0; i < beats.size(); i++) if (lasts[i]) k++;
    check("abort_no_last", 32'(k), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
